// File: rtl/serial_mag_compare_ctrl_pkg.sv
// ============================================================================
// Module   : serial_mag_compare_ctrl_pkg
// Purpose  : Shared FSM encoding and default operand width for the serial
//            magnitude comparator controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_mag_compare_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_mag_compare_ctrl_if.sv
// ============================================================================
// Module   : serial_mag_compare_ctrl_if
// Purpose  : Start/done request bus between a requesting datapath and the
//            serial magnitude comparator controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_mag_compare_ctrl_if
  import serial_mag_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt
  );

endinterface

`default_nettype wire

// File: rtl/serial_mag_compare_ctrl_two_comparator.sv
// ============================================================================
// Module   : two_comparator
// Purpose  : 2-bit cascade magnitude comparator slice; compares the local pair
//            only while the incoming equal flag is set.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module two_comparator (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       gi,
  input  logic       ei,
  input  logic       li,
  output logic       go,
  output logic       eo,
  output logic       lo
);

  always_comb begin
    go = gi;
    eo = ei;
    lo = li;
    if (ei) begin
      go = (a > b);
      eo = (a == b);
      lo = (a < b);
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_mag_compare_ctrl.sv
// ============================================================================
// Module   : serial_mag_compare_ctrl
// Purpose  : Sequences one 2-bit cascade slice over two WIDTH-bit operands,
//            MSB pair first, stopping at the first unequal pair.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_mag_compare_ctrl
  import serial_mag_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_mag_compare_ctrl_if.slave bus
);

  localparam int PAIRS = WIDTH / 2;
  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_mag_compare_ctrl: WIDTH must be even and >= 2");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDX_W-1:0] idx;
  logic             g_flag;
  logic             e_flag;
  logic             l_flag;
  logic [1:0]       pair_a;
  logic [1:0]       pair_b;
  logic             slice_g;
  logic             slice_e;
  logic             slice_l;
  logic             last_pair;
  logic             busy_reg;
  logic             done_reg;
  logic             gt_reg;
  logic             eq_reg;
  logic             lt_reg;

  // Pair mux: select the 2-bit slice of each operand addressed by idx.
  always_comb begin
    pair_a = 2'b00;
    pair_b = 2'b00;
    for (int p = 0; p < PAIRS; p++) begin
      if (idx == IDX_W'(p)) begin
        pair_a = a_reg[2*p +: 2];
        pair_b = b_reg[2*p +: 2];
      end
    end
  end

  two_comparator u_slice (
    .a  (pair_a),
    .b  (pair_b),
    .gi (g_flag),
    .ei (e_flag),
    .li (l_flag),
    .go (slice_g),
    .eo (slice_e),
    .lo (slice_l)
  );

  assign last_pair = !slice_e || (idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = COMPARE;
      COMPARE: if (last_pair) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      idx      <= '0;
      g_flag   <= 1'b0;
      e_flag   <= 1'b1;
      l_flag   <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      gt_reg   <= 1'b0;
      eq_reg   <= 1'b0;
      lt_reg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            idx      <= LAST_IDX;
            g_flag   <= 1'b0;
            e_flag   <= 1'b1;
            l_flag   <= 1'b0;
            busy_reg <= 1'b1;
          end
        end
        COMPARE: begin
          g_flag <= slice_g;
          e_flag <= slice_e;
          l_flag <= slice_l;
          // Results are loaded with the final flags so they are valid while done is high.
          if (last_pair) begin
            done_reg <= 1'b1;
            gt_reg   <= slice_g;
            eq_reg   <= slice_e;
            lt_reg   <= slice_l;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
        end
        default: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.gt   = gt_reg;
  assign bus.eq   = eq_reg;
  assign bus.lt   = lt_reg;

endmodule

`default_nettype wire
